// File: rtl/ctrl_pkg.sv
// ============================================================
// ctrl_pkg : opcode/funct/ALU-op constants and FSM state enum
// Rev 1.0
// ============================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_DONE  = 6'h3F;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB,
    I_EX, I_WB, BRANCH, JUMP, JAL, JR, HALT
  } state_t;

  function automatic logic [2:0] funct_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  funct_alu = ALU_SUB;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================
// mem_wait_timer : completion strobe for one memory access
// Rev 1.0
// ============================================================
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic done_o
);

  logic [3:0] cnt_q;
  logic       hit;

  generate
    if (MEM_HANDSHAKE != 0) begin : g_handshake
      assign hit = mem_ready_i;
    end else begin : g_fixed
      logic unused_ready;
      assign unused_ready = mem_ready_i;
      assign hit = (cnt_q == 4'(MEM_LATENCY - 1));
    end
  endgenerate

  assign done_o = active_i & hit;

  // Cleared outside memory states and on completion, so every access starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt_q <= '0;
    else if (!active_i || done_o) cnt_q <= '0;
    else                         cnt_q <= cnt_q + 4'd1;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================
// multicycle_ctrl : multicycle MIPS-subset control FSM
// Rev 1.0
// ============================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LATENCY   = 1,
  parameter int ILLEGAL_HALT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         MemtoReg,
  output logic               JALselect,
  output logic               halted,
  output logic               illegal,
  output logic               retire
);

  state_t     state_q, state_d;
  logic [2:0] alu_q, alu_d;
  logic       load_q, load_d;
  logic       dec_illegal;
  logic       mem_done;
  logic [2:0] alu_op;

  // The BNE condition is applied in the datapath via PCWriteCond, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  mem_wait_timer #(
    .MEM_HANDSHAKE (MEM_HANDSHAKE),
    .MEM_LATENCY   (MEM_LATENCY)
  ) u_timer (
    .clk         (clk),
    .rst         (reset),
    .active_i    (state_q inside {FETCH, MEM_RD, MEM_WR}),
    .mem_ready_i (mem_ready),
    .done_o      (mem_done)
  );

  always_comb begin
    state_d     = state_q;
    alu_d       = alu_q;
    load_d      = load_q;
    dec_illegal = 1'b0;
    case (state_q)
      FETCH:    if (mem_done) state_d = DECODE;
      DECODE: begin
        load_d = (Op == OP_LW);
        alu_d  = funct_alu(Funct);
        case (Op)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE: begin
            if (Funct == FN_ADD || Funct == FN_SUB || Funct == FN_SLT) state_d = R_EX;
            else if (Funct == FN_JR)                                  state_d = JR;
            else                                                      dec_illegal = 1'b1;
          end
          OP_XORI:  state_d = I_EX;
          OP_BNE:   state_d = BRANCH;
          OP_J:     state_d = JUMP;
          OP_JAL:   state_d = JAL;
          OP_DONE:  state_d = HALT;
          default:  dec_illegal = 1'b1;
        endcase
        if (dec_illegal) state_d = (ILLEGAL_HALT != 0) ? HALT : FETCH;
      end
      MEM_ADDR: state_d = load_q ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_done) state_d = MEM_WB;
      MEM_WR:   if (mem_done) state_d = FETCH;
      R_EX:     state_d = R_WB;
      I_EX:     state_d = I_WB;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      alu_q   <= ALU_ADD;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      load_q  <= load_d;
    end
  end

  // Outputs are forced low while reset is held, even though the state already reads FETCH.
  always_comb begin
    mem_req = 1'b0; IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = 2'd0; ALUSrcA = 1'b0;
    ALUSrcB = 2'd0; alu_op = ALU_ADD; RegWrite = 1'b0; RegDst = 1'b0;
    MemtoReg = 2'd0; JALselect = 1'b0; halted = 1'b0; illegal = 1'b0; retire = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1; ALUSrcB = 2'd1;
          IRWrite = mem_done; PCWrite = mem_done;
        end
        DECODE: begin
          ALUSrcB = 2'd3;
          illegal = dec_illegal;
          retire  = dec_illegal && (ILLEGAL_HALT == 0);
        end
        MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; end
        MEM_RD:   begin mem_req = 1'b1; IorD = 1'b1; end
        MEM_WB:   begin RegWrite = 1'b1; MemtoReg = 2'd1; retire = 1'b1; end
        MEM_WR: begin
          mem_req = 1'b1; IorD = 1'b1; MemWrite = 1'b1; retire = mem_done;
        end
        R_EX:     begin ALUSrcA = 1'b1; alu_op = alu_q; end
        R_WB:     begin RegWrite = 1'b1; RegDst = 1'b1; retire = 1'b1; end
        I_EX:     begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; alu_op = ALU_XOR; end
        I_WB:     begin RegWrite = 1'b1; retire = 1'b1; end
        BRANCH: begin
          ALUSrcA = 1'b1; alu_op = ALU_SUB; PCWriteCond = 1'b1;
          PCSource = 2'd1; retire = 1'b1;
        end
        JUMP:     begin PCWrite = 1'b1; PCSource = 2'd2; retire = 1'b1; end
        JAL: begin
          PCWrite = 1'b1; PCSource = 2'd2; RegWrite = 1'b1;
          JALselect = 1'b1; MemtoReg = 2'd2; retire = 1'b1;
        end
        JR:       begin PCWrite = 1'b1; PCSource = 2'd3; retire = 1'b1; end
        HALT:     halted = 1'b1;
        default:  ;
      endcase
    end
  end

  assign ALUOp = ALUOP_W'(alu_op);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================
// tb_multicycle_ctrl : directed checks of multicycle_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_multicycle_ctrl;

  // Output vector layout:
  // mr iord mw irw pcw pcwc pcs[2] asa asb[2] aluop[3] rw rd mtr[2] jal halt ill ret
  localparam logic [21:0] V_FDONE = 22'b1_0_0_1_1_0_00_0_01_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_FWAIT = 22'b1_0_0_0_0_0_00_0_01_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_DEC   = 22'b0_0_0_0_0_0_00_0_11_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_MADDR = 22'b0_0_0_0_0_0_00_1_10_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_MRD   = 22'b1_1_0_0_0_0_00_0_00_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_MWB   = 22'b0_0_0_0_0_0_00_0_00_000_1_0_01_0_0_0_1;
  localparam logic [21:0] V_MWRW  = 22'b1_1_1_0_0_0_00_0_00_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_MWRD  = 22'b1_1_1_0_0_0_00_0_00_000_0_0_00_0_0_0_1;
  localparam logic [21:0] V_REXA  = 22'b0_0_0_0_0_0_00_1_00_000_0_0_00_0_0_0_0;
  localparam logic [21:0] V_REXS  = 22'b0_0_0_0_0_0_00_1_00_001_0_0_00_0_0_0_0;
  localparam logic [21:0] V_REXT  = 22'b0_0_0_0_0_0_00_1_00_011_0_0_00_0_0_0_0;
  localparam logic [21:0] V_RWB   = 22'b0_0_0_0_0_0_00_0_00_000_1_1_00_0_0_0_1;
  localparam logic [21:0] V_BR    = 22'b0_0_0_0_0_1_01_1_00_001_0_0_00_0_0_0_1;
  localparam logic [21:0] V_JMP   = 22'b0_0_0_0_1_0_10_0_00_000_0_0_00_0_0_0_1;
  localparam logic [21:0] V_JAL   = 22'b0_0_0_0_1_0_10_0_00_000_1_0_10_1_0_0_1;
  localparam logic [21:0] V_JR    = 22'b0_0_0_0_1_0_11_0_00_000_0_0_00_0_0_0_1;
  localparam logic [21:0] V_HALT  = 22'b0_0_0_0_0_0_00_0_00_000_0_0_00_0_1_0_0;
  localparam logic [21:0] V_DILLN = 22'b0_0_0_0_0_0_00_0_11_000_0_0_00_0_0_1_1;
  localparam logic [21:0] V_DILLH = 22'b0_0_0_0_0_0_00_0_11_000_0_0_00_0_0_1_0;

  logic       clk = 1'b0;
  logic       ra, rb, Zero, mem_ready;
  logic [5:0] Op, Funct;
  int         total = 0;
  int         bad = 0;

  logic       a_mr, a_iord, a_mw, a_irw, a_pcw, a_pcwc, a_asa, a_rw, a_rd, a_jal, a_h, a_ill, a_ret;
  logic [1:0] a_pcs, a_asb, a_mtr;
  logic [2:0] a_op;
  logic       b_mr, b_iord, b_mw, b_irw, b_pcw, b_pcwc, b_asa, b_rw, b_rd, b_jal, b_h, b_ill, b_ret;
  logic [1:0] b_pcs, b_asb, b_mtr;
  logic [2:0] b_op;
  logic [21:0] a_vec, b_vec;

  assign a_vec = {a_mr, a_iord, a_mw, a_irw, a_pcw, a_pcwc, a_pcs, a_asa, a_asb, a_op,
                  a_rw, a_rd, a_mtr, a_jal, a_h, a_ill, a_ret};
  assign b_vec = {b_mr, b_iord, b_mw, b_irw, b_pcw, b_pcwc, b_pcs, b_asa, b_asb, b_op,
                  b_rw, b_rd, b_mtr, b_jal, b_h, b_ill, b_ret};

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(3), .MEM_HANDSHAKE(1), .MEM_LATENCY(1), .ILLEGAL_HALT(0)) dut_a (
    .clk(clk), .reset(ra), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(a_mr), .IorD(a_iord), .MemWrite(a_mw), .IRWrite(a_irw), .PCWrite(a_pcw),
    .PCWriteCond(a_pcwc), .PCSource(a_pcs), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ALUOp(a_op),
    .RegWrite(a_rw), .RegDst(a_rd), .MemtoReg(a_mtr), .JALselect(a_jal), .halted(a_h),
    .illegal(a_ill), .retire(a_ret)
  );

  multicycle_ctrl #(.ALUOP_W(3), .MEM_HANDSHAKE(0), .MEM_LATENCY(3), .ILLEGAL_HALT(1)) dut_b (
    .clk(clk), .reset(rb), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(b_mr), .IorD(b_iord), .MemWrite(b_mw), .IRWrite(b_irw), .PCWrite(b_pcw),
    .PCWriteCond(b_pcwc), .PCSource(b_pcs), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_op),
    .RegWrite(b_rw), .RegDst(b_rd), .MemtoReg(b_mtr), .JALselect(b_jal), .halted(b_h),
    .illegal(b_ill), .retire(b_ret)
  );

  task automatic test_reset();
    ra = 1'b1; rb = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (a_vec !== 22'd0) begin bad++; $display("FAIL reset_a got=%b want=%b", a_vec, 22'd0); end
    total++; if (b_vec !== 22'd0) begin bad++; $display("FAIL reset_b got=%b want=%b", b_vec, 22'd0); end
    @(negedge clk);
    ra = 1'b0;
  endtask

  task automatic test_lw();
    logic [21:0] e [5];
    int rets = 0;
    e = '{V_FDONE, V_DEC, V_MADDR, V_MRD, V_MWB};
    Op = 6'h23; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) Op = 6'h2B;  // opcode changes after DECODE must not redirect the load
      #1;
      rets += int'(a_ret);
      total++; if (a_vec !== e[c]) begin bad++; $display("FAIL lw c%0d got=%b want=%b", c, a_vec, e[c]); end
      @(negedge clk);
    end
    total++; if (rets != 1) begin bad++; $display("FAIL lw_retire_count got=%0d want=1", rets); end
  endtask

  task automatic test_sw_wait();
    logic [21:0] e [7];
    logic        r [7];
    int          wr = 0;
    e = '{V_FDONE, V_DEC, V_MADDR, V_MWRW, V_MWRW, V_MWRW, V_MWRD};
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Op = 6'h2B;
    for (int c = 0; c < 7; c++) begin
      mem_ready = r[c];
      #1;
      wr += int'(a_mw);
      total++; if (a_vec !== e[c]) begin bad++; $display("FAIL sw c%0d got=%b want=%b", c, a_vec, e[c]); end
      @(negedge clk);
    end
    total++; if (wr != 4) begin bad++; $display("FAIL sw_memwrite_cycles got=%0d want=4", wr); end
    mem_ready = 1'b1;
  endtask

  task automatic test_rtype();
    logic [21:0] e [8];
    logic [5:0]  f [8];
    e = '{V_FDONE, V_DEC, V_REXS, V_RWB, V_FDONE, V_DEC, V_REXT, V_RWB};
    f = '{6'h22, 6'h22, 6'h20, 6'h20, 6'h2A, 6'h2A, 6'h20, 6'h20};
    Op = 6'h00; mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      Funct = f[c];
      #1;
      total++; if (a_vec !== e[c]) begin bad++; $display("FAIL rtype c%0d got=%b want=%b", c, a_vec, e[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_xori();
    Op = 6'h0E; mem_ready = 1'b1;
    #1; total++; if (a_vec !== V_FDONE) begin bad++; $display("FAIL xori_fetch got=%b want=%b", a_vec, V_FDONE); end
    @(negedge clk); #1;
    total++; if (a_vec !== V_DEC) begin bad++; $display("FAIL xori_decode got=%b want=%b", a_vec, V_DEC); end
    @(negedge clk); #1;
    total++;
    if (a_asb !== 2'd2 || a_op !== 3'd2 || a_rw !== 1'b0 || a_ret !== 1'b0) begin
      bad++; $display("FAIL xori_ex got asb=%0d op=%0d rw=%b ret=%b want asb=2 op=2 rw=0 ret=0", a_asb, a_op, a_rw, a_ret);
    end
    @(negedge clk); #1;
    total++;
    if (a_rw !== 1'b1 || a_rd !== 1'b0 || a_mtr !== 2'd0 || a_ret !== 1'b1 || a_mr !== 1'b0) begin
      bad++; $display("FAIL xori_wb got rw=%b rd=%b mtr=%0d ret=%b mr=%b want rw=1 rd=0 mtr=0 ret=1 mr=0", a_rw, a_rd, a_mtr, a_ret, a_mr);
    end
    @(negedge clk);
  endtask

  task automatic test_bne();
    logic [21:0] e [6];
    e = '{V_FDONE, V_DEC, V_BR, V_FDONE, V_DEC, V_BR};
    Op = 6'h05; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      Zero = (c >= 3);
      #1;
      total++; if (a_vec !== e[c]) begin bad++; $display("FAIL bne c%0d got=%b want=%b", c, a_vec, e[c]); end
      @(negedge clk);
    end
    Zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [21:0] e [9];
    logic [5:0]  o [9];
    e = '{V_FDONE, V_DEC, V_JMP, V_FDONE, V_DEC, V_JAL, V_FDONE, V_DEC, V_JR};
    o = '{6'h02, 6'h02, 6'h02, 6'h03, 6'h03, 6'h03, 6'h00, 6'h00, 6'h00};
    Funct = 6'h08; mem_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      Op = o[c];
      #1;
      total++; if (a_vec !== e[c]) begin bad++; $display("FAIL jump c%0d got=%b want=%b", c, a_vec, e[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_nop();
    logic [21:0] e [5];
    logic [5:0]  o [5];
    logic [5:0]  f [5];
    logic        r [5];
    e = '{V_FDONE, V_DILLN, V_FDONE, V_DILLN, V_FWAIT};
    o = '{6'h11, 6'h11, 6'h00, 6'h00, 6'h00};
    f = '{6'h20, 6'h20, 6'h21, 6'h21, 6'h21};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      Op = o[c]; Funct = f[c]; mem_ready = r[c];
      #1;
      total++; if (a_vec !== e[c]) begin bad++; $display("FAIL illegal c%0d got=%b want=%b", c, a_vec, e[c]); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_halt();
    Op = 6'h3F; mem_ready = 1'b1;
    #1; total++; if (a_vec !== V_FDONE) begin bad++; $display("FAIL halt_fetch got=%b want=%b", a_vec, V_FDONE); end
    @(negedge clk); #1;
    total++; if (a_vec !== V_DEC) begin bad++; $display("FAIL halt_decode got=%b want=%b", a_vec, V_DEC); end
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      Op = (c < 10) ? 6'h23 : 6'h00;
      #1;
      total++; if (a_vec !== V_HALT) begin bad++; $display("FAIL halt c%0d got=%b want=%b", c, a_vec, V_HALT); end
      @(negedge clk);
    end
  endtask

  task automatic test_fixed_latency();
    logic [21:0] e1 [5];
    logic [21:0] e2 [6];
    e1 = '{V_FWAIT, V_FWAIT, V_FDONE, V_DEC, V_REXA};
    e2 = '{V_FWAIT, V_FWAIT, V_FDONE, V_DILLH, V_HALT, V_HALT};
    Op = 6'h00; Funct = 6'h20; mem_ready = 1'b0;
    rb = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (b_vec !== e1[c]) begin bad++; $display("FAIL fixed c%0d got=%b want=%b", c, b_vec, e1[c]); end
      if (c < 4) @(negedge clk);
    end
    #1 rb = 1'b1;  // reset lands in the middle of R_EX
    #1;
    total++; if (b_vec !== 22'd0) begin bad++; $display("FAIL fixed_reset_now got=%b want=%b", b_vec, 22'd0); end
    @(negedge clk); #1;
    total++; if (b_vec !== 22'd0) begin bad++; $display("FAIL fixed_reset_hold got=%b want=%b", b_vec, 22'd0); end
    @(negedge clk);
    rb = 1'b0; Op = 6'h11; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (b_vec !== e2[c]) begin bad++; $display("FAIL fixed_post c%0d got=%b want=%b", c, b_vec, e2[c]); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_xori();
    test_bne();
    test_jumps();
    test_illegal_nop();
    test_halt();
    test_fixed_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
